// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, injector FSM states and the 1of2 digit encoder.
package noc_pkg;

  localparam int FLIT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RTZ
  } tx_state_t;

  // Returns {rail1, rail0} for one dual-rail digit; exactly one rail is high.
  function automatic logic [1:0] enc1of2(input logic b);
    return {b, ~b};
  endfunction

endpackage

// File: rtl/en_sync.sv
// Two-flop synchronizer bringing the router's asynchronous enable into the CLK domain.
module en_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // The first flop may go metastable; only the second flop's output is used downstream.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/leaf_inject_tx.sv
// PE-to-router injector: flit FIFO feeding a 4-phase dual-rail (1of2) transmitter.
// Optional flit counter output enabled by defining LEAF_INJECT_TX_STATS_EN.
module leaf_inject_tx
  import noc_pkg::*;
#(
  parameter int W     = FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic [W-1:0]             out_d0,
  output logic [W-1:0]             out_d1,
  input  logic                     out_e,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef LEAF_INJECT_TX_STATS_EN
  ,
  output logic [31:0]              flit_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          eSync;
  logic          push;
  logic          pop;
  logic [W-1:0]  headFlit;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  rail0_q, rail0_d;
  logic [W-1:0]  rail1_q, rail1_d;
  tx_state_t     state_q, state_d;

  en_sync u_en_sync (
    .clk_i   (CLK),
    .reset_i (RESET),
    .d_i     (out_e),
    .q_o     (eSync)
  );

  assign in_ready  = ~RESET & (count_q < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign headFlit  = mem_q[rdPtr_q];
  assign occupancy = count_q;
  assign out_d0    = rail0_q;
  assign out_d1    = rail1_q;

  // Storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

  // Handshake: IDLE issues a token, DATA waits for the enable to fall, RTZ waits for it to rise.
  always_comb begin
    state_d = state_q;
    rail0_d = rail0_q;
    rail1_d = rail1_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && eSync) begin
          for (int b = 0; b < W; b++) begin
            {rail1_d[b], rail0_d[b]} = enc1of2(headFlit[b]);
          end
          pop     = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!eSync) begin
          rail0_d = '0;
          rail1_d = '0;
          state_d = RTZ;
        end
      end
      RTZ: begin
        if (eSync) begin
          state_d = IDLE;
        end
      end
      default: begin
        rail0_d = '0;
        rail1_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      rail0_q <= '0;
      rail1_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rail0_q <= rail0_d;
      rail1_q <= rail1_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef LEAF_INJECT_TX_STATS_EN
  logic [31:0] flitCount_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flitCount_q <= '0;
    end else if ((state_q == IDLE) && (state_d == DATA)) begin
      flitCount_q <= flitCount_q + 32'd1;
    end
  end

  assign flit_count = flitCount_q;
`endif

endmodule

// File: tb/tb_leaf_inject_tx.sv
// Directed self-checking bench for leaf_inject_tx; acts as PE source and router-side 4-phase responder.
module tb_leaf_inject_tx;
  import noc_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;
  logic [8:0] out_d0;
  logic [8:0] out_d1;
  logic       out_e;
  logic [2:0] occupancy;
`ifdef LEAF_INJECT_TX_STATS_EN
  logic [31:0] flitCount;
`endif

  int checks;
  int errors;
  int overlapCount;
  logic [8:0] sentQ[$];

  leaf_inject_tx #(
    .W     (9),
    .DEPTH (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_e     (out_e),
    .occupancy (occupancy)
`ifdef LEAF_INJECT_TX_STATS_EN
    ,
    .flit_count(flitCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // A digit with both rails high is never legal, whatever the state.
  always @(negedge CLK) begin
    if (!RESET && ((out_d0 & out_d1) != '0)) overlapCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitToken(output logic [8:0] r1, output logic [8:0] r0);
    int n = 0;
    while ((out_d0 | out_d1) == '0 && n < 60) begin
      tick();
      n++;
    end
    r1 = out_d1;
    r0 = out_d0;
  endtask

  task automatic returnToZero(input int dlyFall, input int dlyRise, input string tag);
    int n = 0;
    repeat (dlyFall) tick();
    out_e = 1'b0;
    while ((out_d0 | out_d1) != '0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rtz"}, {14'd0, out_d1, out_d0}, 32'd0);
    repeat (dlyRise) tick();
    out_e = 1'b1;
  endtask

  task automatic consumeFlit(input logic [8:0] exp, input string tag);
    logic [8:0] r1, r0, inv;
    inv = ~exp;
    waitToken(r1, r0);
    checkOutput({tag, "_d1"}, {23'd0, r1}, {23'd0, exp});
    checkOutput({tag, "_d0"}, {23'd0, r0}, {23'd0, inv});
    returnToZero(0, 0, tag);
  endtask

  initial begin
    logic [8:0] pushVal;
    logic [8:0] r1, r0, expV, invV;
    int pushWait;

    checks = 0;
    errors = 0;
    overlapCount = 0;
    RESET = 1'b1;
    out_e = 1'b0;
    applyStimulus(1'b0, 9'h000);

    // Reset state
    tick();
    tick();
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_occupancy", {29'd0, occupancy}, 32'd0);
    checkOutput("reset_rails", {14'd0, out_d1, out_d0}, 32'd0);
    checkOutput("reset_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    RESET = 1'b0;
    tick();
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Single flit with latency t+1
    out_e = 1'b1;
    tick();
    tick();
    applyStimulus(1'b1, 9'h1A5);
    tick();
    applyStimulus(1'b0, 9'h000);
    checkOutput("single_occ_after_push", {29'd0, occupancy}, 32'd1);
    checkOutput("single_rails_not_yet", {14'd0, out_d1, out_d0}, 32'd0);
    tick();
    checkOutput("single_d1", {23'd0, out_d1}, 32'h1A5);
    checkOutput("single_d0", {23'd0, out_d0}, 32'h05A);
    checkOutput("single_occ_after_pop", {29'd0, occupancy}, 32'd0);
    out_e = 1'b0;
    tick();
    tick();
    checkOutput("single_held_d1", {23'd0, out_d1}, 32'h1A5);
    tick();
    checkOutput("single_rtz_3cyc", {14'd0, out_d1, out_d0}, 32'd0);
    out_e = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("single_back_idle", {30'd0, dut.state_q}, {30'd0, IDLE});

    // Fill with enable held low
    out_e = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 9'(9'h010 + i));
      checkOutput($sformatf("fill_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      tick();
    end
    applyStimulus(1'b1, 9'h114);
    checkOutput("fill_full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fill_full_occ", {29'd0, occupancy}, 32'd4);
    tick();
    checkOutput("fill_fifth_rejected", {29'd0, occupancy}, 32'd4);
    out_e = 1'b1;
    tick();
    tick();
    checkOutput("fill_still_full", {29'd0, occupancy}, 32'd4);
    tick();
    checkOutput("fill_pop_d1", {23'd0, out_d1}, 32'h010);
    checkOutput("fill_pop_occ", {29'd0, occupancy}, 32'd3);
    checkOutput("fill_pop_ready", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 9'h000);
    checkOutput("fill_fifth_accepted", {29'd0, occupancy}, 32'd4);
    consumeFlit(9'h010, "fill0");
    consumeFlit(9'h011, "fill1");
    consumeFlit(9'h012, "fill2");
    consumeFlit(9'h013, "fill3");
    consumeFlit(9'h114, "fill4");

    // Simultaneous push and pop at occupancy 2, write pointer wrapping 3 -> 0
    tick();
    tick();
    tick();
    tick();
    out_e = 1'b0;
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 9'h0A0);
    tick();
    applyStimulus(1'b1, 9'h15B);
    tick();
    applyStimulus(1'b0, 9'h000);
    out_e = 1'b1;
    tick();
    tick();
    checkOutput("pp_occ_before", {29'd0, occupancy}, 32'd2);
    applyStimulus(1'b1, 9'h1A2);
    tick();
    applyStimulus(1'b0, 9'h000);
    checkOutput("pp_occ_after", {29'd0, occupancy}, 32'd2);
    checkOutput("pp_head_d1", {23'd0, out_d1}, 32'h0A0);
    consumeFlit(9'h0A0, "pp0");
    consumeFlit(9'h15B, "pp1");
    consumeFlit(9'h1A2, "pp2");

    // Reset while in DATA with a flit still queued
    tick();
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 9'h0C3);
    tick();
    applyStimulus(1'b1, 9'h13C);
    tick();
    applyStimulus(1'b0, 9'h000);
    checkOutput("rst_pre_d1", {23'd0, out_d1}, 32'h0C3);
    checkOutput("rst_pre_occ", {29'd0, occupancy}, 32'd1);
    RESET = 1'b1;
    tick();
    checkOutput("rst_rails", {14'd0, out_d1, out_d0}, 32'd0);
    checkOutput("rst_occ", {29'd0, occupancy}, 32'd0);
    checkOutput("rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    RESET = 1'b0;
    tick();
    checkOutput("rst_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    tick();
    checkOutput("rst_discarded", {14'd0, out_d1, out_d0}, 32'd0);

    // Stream of 16 random flits against a random-delay responder
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          pushVal = 9'($urandom_range(0, 511));
          applyStimulus(1'b1, pushVal);
          pushWait = 0;
          while (!in_ready && pushWait < 200) begin
            tick();
            pushWait++;
          end
          sentQ.push_back(pushVal);
          tick();
          applyStimulus(1'b0, 9'h000);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int k = 0; k < 16; k++) begin
          waitToken(r1, r0);
          if (sentQ.size() > 0) expV = sentQ.pop_front();
          else expV = 'x;
          invV = ~expV;
          checkOutput($sformatf("stream%0d_d1", k), {23'd0, r1}, {23'd0, expV});
          checkOutput($sformatf("stream%0d_d0", k), {23'd0, r0}, {23'd0, invV});
          returnToZero($urandom_range(1, 7), $urandom_range(1, 7), $sformatf("stream%0d", k));
        end
      end
    join

    tick();
    checkOutput("stream_occ_empty", {29'd0, occupancy}, 32'd0);
    checkOutput("rail_overlap_cycles", overlapCount, 32'd0);
`ifdef LEAF_INJECT_TX_STATS_EN
    checkOutput("flit_count", flitCount, 32'd16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leaf_inject_tx.md
LEAF_INJECT_TX -- requirements
Module: leaf_inject_tx

Interface
REQ-001 SHALL have parameter W, default 9, meaning number of dual-rail digits per flit (matches the router 1of2 x9 channel).
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-003 SHALL have port CLK, input, 1, meaning the single clock.
REQ-004 SHALL have port RESET, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the PE flit is valid.
REQ-006 SHALL have port in_data, input, W, meaning the PE flit.
REQ-007 SHALL have port in_ready, output, 1, meaning the FIFO can accept a flit.
REQ-008 SHALL have ports out_d0 and out_d1, output, W each, meaning rail 0 and rail 1 of each 1of2 digit toward the router leaf decoder.
REQ-009 SHALL have port out_e, input, 1, meaning asynchronous enable from the router (1 = ready for a token).
REQ-010 SHALL have port occupancy, output, $clog2(DEPTH)+1, meaning the FIFO entry count.

Function
REQ-011 SHALL accept a flit on a rising CLK when in_valid && in_ready; in_ready = (occupancy < DEPTH); there is no write-through when full.
REQ-012 SHALL pass out_e through a 2-flop synchronizer (e_sync, reset 0) before any use.
REQ-013 SHALL implement FSM states IDLE, DATA, RTZ, reset to IDLE.
REQ-014 IDLE: out_d0 = out_d1 = 0; if occupancy > 0 && e_sync, on that edge SHALL load the head flit into the rail registers (bit b: d1[b] = in_data[b], d0[b] = ~in_data[b]), pop the FIFO, and go to DATA.
REQ-015 DATA: rails held stable; when e_sync == 0, on that edge SHALL clear all rails and go to RTZ.
REQ-016 RTZ: rails neutral; when e_sync == 1, SHALL go to IDLE.
REQ-017 Rails SHALL be driven only from flops, never from combinational logic.
REQ-018 Exactly one rail per digit SHALL be high in DATA, and both rails SHALL be low in IDLE and RTZ.
REQ-019 Latency SHALL be: a flit written into an empty FIFO at edge t, with e_sync = 1 and state IDLE, appears on the rails after edge t+1.
REQ-020 On a simultaneous push and pop, occupancy SHALL stay unchanged and both operations SHALL take effect.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 Flits SHALL leave in arrival order with no loss or duplication.
REQ-023 The minimum handshake SHALL be 3 cycles plus 2x synchronizer delay per flit, and the block SHALL NOT issue back-to-back tokens without a full return-to-zero.

Reset
REQ-024 With RESET high at an edge: state IDLE, rails 0, occupancy 0, pointers 0, synchronizer 0, in_ready 0 while RESET is high and 1 on the first cycle after release.
REQ-025 Reset mid-handshake SHALL drop rails to neutral on that edge and discard FIFO contents; re-synchronisation of the router is the system's responsibility.

Configuration
REQ-026 Macro LEAF_INJECT_TX_STATS_EN: when defined, SHALL add output flit_count (32 bits), reset 0, incremented on each IDLE->DATA transition and wrapping at 2^32-1 -> 0.
REQ-027 Without LEAF_INJECT_TX_STATS_EN, the port and counter SHALL NOT exist, and behaviour SHALL otherwise be identical.

Structure
REQ-028 Package noc_pkg SHALL hold FLIT_W = 9, the tx_state_t enum (IDLE, DATA, RTZ), and the 1of2 encode function.
REQ-029 The synchronizer SHALL be sub-module en_sync (2-flop, synchronous active-high reset to 0); the FIFO SHALL be inline.

Verification
REQ-030 Single flit: reset, out_e = 1, push 9'h1A5 -> rails d1 = 9'h1A5, d0 = 9'h05A after edge t+1; drop out_e -> rails 0 within 3 cycles.
REQ-031 Fill: out_e held 0, push 5 flits -> first 4 accepted, in_ready = 0, occupancy = 4, fifth not accepted until a pop.
REQ-032 Stream: push 16 random flits with a random out_e responder (1-7 cycle delays) -> received sequence equals sent order, and no cycle has both rails high.
REQ-033 Simultaneous push and pop at occupancy 2 -> occupancy stays 2 and pointers wrap correctly past DEPTH-1.
REQ-034 Reset asserted in DATA -> rails 0, occupancy 0, and state IDLE on the next edge.
REQ-035 With LEAF_INJECT_TX_STATS_EN defined, 16 flits sent -> flit_count = 16; a build without the macro compiles without the port.
